// File: rtl/vadd_lanes_pkg.sv
// Shared types and constants for the vadd_lanes lane-parallel stream adder.
// Holds the FSM state enum, beat counter width and the legal lane geometry.
package vadd_lanes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int BEAT_CNT_W = 32;
  localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_MAX = '1;

  localparam int LANES_MIN = 1;
  localparam int LANES_MAX = 16;

  function automatic bit elem_w_legal(input int w);
    return (w == 8) || (w == 16) || (w == 32) || (w == 64);
  endfunction

  function automatic bit cfg_legal(input int lanes, input int w, input int tdata_w);
    return (lanes >= LANES_MIN) && (lanes <= LANES_MAX) && elem_w_legal(w)
           && (tdata_w == lanes * w);
  endfunction

endpackage

// File: rtl/vadd_lane.sv
// One combinational lane: a+b or a-b over ELEM_W bits.
// With VADD_LANES_SAT_EN defined the result is clamped to the signed range.
module vadd_lane #(
  parameter int ELEM_W = 32
) (
  input  logic [ELEM_W-1:0] a_i,
  input  logic [ELEM_W-1:0] b_i,
  input  logic              sub_i,
  output logic [ELEM_W-1:0] c_o
);

`ifdef VADD_LANES_SAT_EN
  logic [ELEM_W:0] a_x;
  logic [ELEM_W:0] b_x;
  logic [ELEM_W:0] r_x;
  logic            ovf;

  // One guard bit is enough: overflow shows as the two top bits disagreeing.
  always_comb begin
    a_x = {a_i[ELEM_W-1], a_i};
    b_x = {b_i[ELEM_W-1], b_i};
    r_x = sub_i ? (a_x - b_x) : (a_x + b_x);
    ovf = r_x[ELEM_W] ^ r_x[ELEM_W-1];
    if (!ovf) begin
      c_o = r_x[ELEM_W-1:0];
    end else if (r_x[ELEM_W]) begin
      c_o = {1'b1, {(ELEM_W-1){1'b0}}};
    end else begin
      c_o = {1'b0, {(ELEM_W-1){1'b1}}};
    end
  end
`else
  assign c_o = sub_i ? (a_i - b_i) : (a_i + b_i);
`endif

endmodule

// File: rtl/vadd_lanes.sv
// Joins two AXIS streams beat by beat and emits per-lane sums/differences.
// Optional signed saturation per lane is enabled by defining VADD_LANES_SAT_EN.
module vadd_lanes
  import vadd_lanes_pkg::*;
#(
  parameter int LANES              = 4,
  parameter int ELEM_W             = 32,
  parameter int C_AXIS_TDATA_WIDTH = LANES * ELEM_W
) (
  input  logic                            ap_aclk,
  input  logic                            ap_aresetn,
  input  logic                            ap_start,
  input  logic                            ap_sub,
  output logic                            ap_idle,
  output logic                            ap_done,
  output logic                            err_last,
  output logic [BEAT_CNT_W-1:0]           beat_count,
  output state_e                          dbg_state,
  input  logic                            s_axis_a_tvalid,
  output logic                            s_axis_a_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_a_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_a_tkeep,
  input  logic                            s_axis_a_tlast,
  input  logic                            s_axis_b_tvalid,
  output logic                            s_axis_b_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_b_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_b_tkeep,
  input  logic                            s_axis_b_tlast,
  output logic                            m_axis_c_tvalid,
  input  logic                            m_axis_c_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_c_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_c_tkeep,
  output logic                            m_axis_c_tlast
);

  localparam int DW = C_AXIS_TDATA_WIDTH;
  localparam int KW = C_AXIS_TDATA_WIDTH / 8;

  if (!cfg_legal(LANES, ELEM_W, C_AXIS_TDATA_WIDTH)) begin : g_bad_cfg
    $error("vadd_lanes: illegal LANES/ELEM_W/C_AXIS_TDATA_WIDTH combination");
  end

  // Handshake rule for all three streams: a beat moves on a rising edge where
  // tvalid and tready are both high; a raised tvalid holds its payload until then.
  state_e                  state_q, state_d;
  logic                    sub_q, sub_d;
  logic                    err_q, err_d;
  logic [BEAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    c_valid_q, c_valid_d;
  logic [DW-1:0]           c_data_q, c_data_d;
  logic [KW-1:0]           c_keep_q, c_keep_d;
  logic                    c_last_q, c_last_d;
  logic [DW-1:0]           lane_res;
  logic                    both_valid, slot_free, join_ok, out_hs, start_ok, in_last;

  assign both_valid = s_axis_a_tvalid && s_axis_b_tvalid;
  assign slot_free  = !c_valid_q || m_axis_c_tready;
  assign join_ok    = (state_q == ST_RUN) && both_valid && slot_free;
  assign out_hs     = c_valid_q && m_axis_c_tready;
  assign start_ok   = (state_q == ST_IDLE) && ap_start;
  assign in_last    = s_axis_a_tlast || s_axis_b_tlast;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vadd_lane #(.ELEM_W(ELEM_W)) u_lane (
      .a_i   (s_axis_a_tdata[g*ELEM_W +: ELEM_W]),
      .b_i   (s_axis_b_tdata[g*ELEM_W +: ELEM_W]),
      .sub_i (sub_q),
      .c_o   (lane_res[g*ELEM_W +: ELEM_W])
    );
  end

  always_ff @(posedge ap_aclk) begin
    if (!ap_aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ap_start) state_d = ST_RUN;
      ST_RUN:   if (join_ok && in_last) state_d = ST_DRAIN;
      // Only the tlast beat can still be in the output register here.
      ST_DRAIN: if (out_hs) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ap_idle         = (state_q == ST_IDLE);
    ap_done         = (state_q == ST_DONE);
    s_axis_a_tready = 1'b0;
    s_axis_b_tready = 1'b0;
    if (state_q == ST_RUN) begin
      s_axis_a_tready = both_valid && slot_free;
      s_axis_b_tready = both_valid && slot_free;
    end
  end

  always_comb begin
    sub_d     = start_ok ? ap_sub : sub_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    c_valid_d = c_valid_q;
    c_data_d  = c_data_q;
    c_keep_d  = c_keep_q;
    c_last_d  = c_last_q;
    if (start_ok) begin
      err_d = 1'b0;
    end else if (join_ok && (s_axis_a_tlast != s_axis_b_tlast)) begin
      err_d = 1'b1;
    end
    if (start_ok) begin
      cnt_d = '0;
    end else if (out_hs && (cnt_q != BEAT_CNT_MAX)) begin
      cnt_d = cnt_q + BEAT_CNT_W'(1);
    end
    // A join in the same cycle as an output handshake simply overwrites the slot.
    if (join_ok) begin
      c_valid_d = 1'b1;
      c_data_d  = lane_res;
      c_keep_d  = s_axis_a_tkeep & s_axis_b_tkeep;
      c_last_d  = in_last;
    end else if (out_hs) begin
      c_valid_d = 1'b0;
    end
  end

  always_ff @(posedge ap_aclk) begin
    if (!ap_aresetn) begin
      sub_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      c_valid_q <= 1'b0;
      c_data_q  <= '0;
      c_keep_q  <= '0;
      c_last_q  <= 1'b0;
    end else begin
      sub_q     <= sub_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      c_valid_q <= c_valid_d;
      c_data_q  <= c_data_d;
      c_keep_q  <= c_keep_d;
      c_last_q  <= c_last_d;
    end
  end

  assign err_last        = err_q;
  assign beat_count      = cnt_q;
  assign dbg_state       = state_q;
  assign m_axis_c_tvalid = c_valid_q;
  assign m_axis_c_tdata  = c_data_q;
  assign m_axis_c_tkeep  = c_keep_q;
  assign m_axis_c_tlast  = c_last_q;

endmodule

// File: tb/tb_vadd_lanes.sv
// Directed-plus-random bench for vadd_lanes (4 lanes x 32 bits) with a lane-arithmetic
// reference model; expectations follow VADD_LANES_SAT_EN when it is defined.
module tb_vadd_lanes;
  import vadd_lanes_pkg::*;

  localparam int LANES = 4;
  localparam int EW    = 32;
  localparam int DW    = LANES * EW;
  localparam int KW    = DW / 8;
  localparam int PW    = DW + KW + 1;
  localparam longint SMAX = (longint'(1) << (EW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (EW - 1));

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          ap_start = 1'b0, ap_sub = 1'b0;
  logic          ap_idle, ap_done, err_last;
  logic [31:0]   beat_count;
  state_e        dbg_state;
  logic          a_tvalid = 1'b0, b_tvalid = 1'b0, m_tready = 1'b0;
  logic          a_tready, b_tready, m_tvalid;
  logic [DW-1:0] a_tdata = '0, b_tdata = '0, m_tdata;
  logic [KW-1:0] a_tkeep = '0, b_tkeep = '0, m_tkeep;
  logic          a_tlast = 1'b0, b_tlast = 1'b0, m_tlast;

  vadd_lanes #(.LANES(LANES), .ELEM_W(EW)) dut (
    .ap_aclk(clk), .ap_aresetn(rstn), .ap_start(ap_start), .ap_sub(ap_sub),
    .ap_idle(ap_idle), .ap_done(ap_done), .err_last(err_last), .beat_count(beat_count),
    .dbg_state(dbg_state),
    .s_axis_a_tvalid(a_tvalid), .s_axis_a_tready(a_tready), .s_axis_a_tdata(a_tdata),
    .s_axis_a_tkeep(a_tkeep), .s_axis_a_tlast(a_tlast),
    .s_axis_b_tvalid(b_tvalid), .s_axis_b_tready(b_tready), .s_axis_b_tdata(b_tdata),
    .s_axis_b_tkeep(b_tkeep), .s_axis_b_tlast(b_tlast),
    .m_axis_c_tvalid(m_tvalid), .m_axis_c_tready(m_tready), .m_axis_c_tdata(m_tdata),
    .m_axis_c_tkeep(m_tkeep), .m_axis_c_tlast(m_tlast)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0;
  int done_cyc = -1;
  always @(negedge clk) begin
    if (ap_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [PW-1:0] exp_q[$];
  logic [DW-1:0] a_data[16], b_data[16];
  logic [KW-1:0] a_keep[16], b_keep[16];
  logic          a_last[16], b_last[16];
  logic          cur_sub = 1'b0;
  int            last_hs_cyc = -1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Reference: each lane is an independent signed integer sum/difference.
  function automatic logic [DW-1:0] ref_c(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic sub);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      longint sa = longint'($signed(a[l*EW +: EW]));
      longint sb = longint'($signed(b[l*EW +: EW]));
      longint s  = sub ? (sa - sb) : (sa + sb);
`ifdef VADD_LANES_SAT_EN
      if (s > SMAX) s = SMAX;
      else if (s < SMIN) s = SMIN;
`endif
      r[l*EW +: EW] = s[EW-1:0];
    end
    return r;
  endfunction

  task automatic push_expected(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({ref_c(a_data[i], b_data[i], cur_sub), a_keep[i] & b_keep[i],
                       a_last[i] | b_last[i]});
  endtask

  task automatic fill_random(input int n, input int la, input int lb);
    for (int i = 0; i < n; i++) begin
      a_data[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      b_data[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      a_keep[i] = KW'($urandom());
      b_keep[i] = KW'($urandom());
      a_last[i] = (i == la);
      b_last[i] = (i == lb);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rstn = 1'b0;
    repeat (cycles) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic start_run(input logic sub);
    @(negedge clk);
    ap_start = 1'b1;
    ap_sub   = sub;
    cur_sub  = sub;
    @(negedge clk);
    ap_start = 1'b0;
    ap_sub   = 1'b0;
  endtask

  task automatic put_beat(input bit is_b, input int i, input logic v);
    if (is_b) begin
      b_tvalid = v; b_tdata = b_data[i]; b_tkeep = b_keep[i]; b_tlast = b_last[i];
    end else begin
      a_tvalid = v; a_tdata = a_data[i]; a_tkeep = a_keep[i]; a_tlast = a_last[i];
    end
  endtask

  task automatic drive_src(input bit is_b, input int n, input int first_delay, input int max_gap);
    int guard;
    repeat (first_delay) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      int gap = (i == 0) ? 0 : $urandom_range(0, max_gap);
      repeat (gap) begin
        @(negedge clk);
        if (is_b) b_tvalid = 1'b0; else a_tvalid = 1'b0;
      end
      @(negedge clk);
      put_beat(is_b, i, 1'b1);
      #1;
      guard = 0;
      while (!(is_b ? b_tready : a_tready) && guard < 2000) begin
        if (!is_b) check("tready_pair", a_tready, b_tready);
        @(negedge clk);
        #1;
        guard++;
      end
      if (!is_b) check("tready_pair", a_tready, b_tready);
      if (guard >= 2000) begin
        fail_now(is_b ? "src_b_accept" : "src_a_accept");
        break;
      end
    end
    @(negedge clk);
    if (is_b) b_tvalid = 1'b0; else a_tvalid = 1'b0;
  endtask

  task automatic sink(input int n, input int mode);
    int got = 0;
    int guard = 0;
    bit held = 0;
    logic [PW-1:0] held_v, cur, exp;
    while (got < n && guard < 3000) begin
      @(negedge clk);
      case (mode)
        0: m_tready = 1'b1;
        1: m_tready = cyc[0];
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
      #1;
      guard++;
      cur = {m_tdata, m_tkeep, m_tlast};
      if (held) check("c_hold_stable", {m_tvalid, cur}, {1'b1, held_v});
      held   = m_tvalid && !m_tready;
      held_v = cur;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("c_unexpected_beat", cur, '0);
        end else begin
          exp = exp_q.pop_front();
          check("c_beat", cur, exp);
        end
        got++;
        last_hs_cyc = cyc;
      end
    end
    if (got < n) fail_now("sink_beats");
    @(negedge clk);
    m_tready = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (ap_idle !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) fail_now("wait_idle");
  endtask

  // ---------------- directed steps ----------------
  initial begin
    int base;
    logic [DW-1:0] exp_add, exp_sub;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_idle", ap_idle, 1'b1);
    check("rst_done", ap_done, 1'b0);
    check("rst_err", err_last, 1'b0);
    check("rst_count", beat_count, 32'd0);
    check("rst_tready", {a_tready, b_tready}, 2'b00);
    check("rst_out", {m_tvalid, m_tdata, m_tkeep, m_tlast}, '0);
    check("rst_state", dbg_state, ST_IDLE);
    rstn = 1'b1;

    // Single beat A={1,2,3,4} + B={10,20,30,40}
    a_data[0] = {32'd4, 32'd3, 32'd2, 32'd1};
    b_data[0] = {32'd40, 32'd30, 32'd20, 32'd10};
    a_keep[0] = '1; b_keep[0] = '1; a_last[0] = 1'b1; b_last[0] = 1'b1;
    exp_q.push_back({32'd44, 32'd33, 32'd22, 32'd11, 16'hFFFF, 1'b1});
    base = done_cnt;
    start_run(1'b0);
    #1;
    check("run_state", dbg_state, ST_RUN);
    check("run_not_idle", ap_idle, 1'b0);
    fork
      drive_src(1'b0, 1, 0, 0);
      drive_src(1'b1, 1, 0, 0);
      sink(1, 0);
    join
    wait_idle();
    check("single_count", beat_count, 32'd1);
    check("single_done_pulses", done_cnt - base, 1);
    check("single_done_latency", done_cyc, last_hs_cyc + 1);
    check("single_err", err_last, 1'b0);

    // Lane overflow boundaries, add then sub
    a_data[0] = {32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    b_data[0] = {32'd3, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001};
`ifdef VADD_LANES_SAT_EN
    exp_add = {32'd8, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF};
`else
    exp_add = {32'd8, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
`endif
    exp_q.push_back({exp_add, 16'hFFFF, 1'b1});
    start_run(1'b0);
    fork
      drive_src(1'b0, 1, 0, 0);
      drive_src(1'b1, 1, 0, 0);
      sink(1, 0);
    join
    wait_idle();
    a_data[0] = {32'd10, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    b_data[0] = {32'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
`ifdef VADD_LANES_SAT_EN
    exp_sub = {32'd7, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
`else
    exp_sub = {32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
`endif
    exp_q.push_back({exp_sub, 16'hFFFF, 1'b1});
    start_run(1'b1);
    fork
      drive_src(1'b0, 1, 0, 0);
      drive_src(1'b1, 1, 0, 0);
      sink(1, 0);
    join
    wait_idle();

    // 8-beat random stream, toggling m_tready, B delayed 3 cycles
    fill_random(8, 7, 7);
    base = done_cnt;
    start_run(1'($urandom_range(0, 1)));
    push_expected(8);
    fork
      drive_src(1'b0, 8, 0, 1);
      drive_src(1'b1, 8, 3, 1);
      sink(8, 1);
    join
    wait_idle();
    check("bp_count", beat_count, 32'd8);
    check("bp_queue_empty", exp_q.size(), 0);
    check("bp_done_pulses", done_cnt - base, 1);

    // tlast mismatch: A last on beat 3, B's last would be beat 4
    fill_random(4, 2, 3);
    base = done_cnt;
    start_run(1'($urandom_range(0, 1)));
    push_expected(3);
    fork
      drive_src(1'b0, 3, 0, 2);
      drive_src(1'b1, 3, 0, 2);
      sink(3, 2);
    join
    wait_idle();
    check("mm_err_last", err_last, 1'b1);
    check("mm_count", beat_count, 32'd3);
    check("mm_done_pulses", done_cnt - base, 1);
    repeat (3) @(negedge clk);
    #1;
    check("mm_err_sticky", err_last, 1'b1);

    // Reset with an output beat held under backpressure
    fill_random(1, 5, 5);
    start_run(1'b0);
    #1;
    check("restart_err_clear", err_last, 1'b0);
    check("restart_count_clear", beat_count, 32'd0);
    @(negedge clk);
    m_tready = 1'b0;
    put_beat(1'b0, 0, 1'b1);
    put_beat(1'b1, 0, 1'b1);
    @(negedge clk);
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    #1;
    check("held_valid", m_tvalid, 1'b1);
    check("held_data", m_tdata, ref_c(a_data[0], b_data[0], 1'b0));
    base = done_cnt;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rst_mid_valid", m_tvalid, 1'b0);
    check("rst_mid_idle", ap_idle, 1'b1);
    check("rst_mid_data", m_tdata, '0);
    check("rst_mid_count", beat_count, 32'd0);
    repeat (4) @(negedge clk);
    check("rst_mid_no_done", done_cnt - base, 0);
    fill_random(4, 3, 3);
    base = done_cnt;
    start_run(1'b1);
    push_expected(4);
    fork
      drive_src(1'b0, 4, 0, 2);
      drive_src(1'b1, 4, 1, 2);
      sink(4, 2);
    join
    wait_idle();
    check("post_rst_count", beat_count, 32'd4);
    check("post_rst_done", done_cnt - base, 1);

    // ap_start pulsed mid-run is ignored; keep is the AND of both sides
    fill_random(6, 5, 5);
    for (int i = 0; i < 6; i++) begin
      a_keep[i] = 16'hFFFF;
      b_keep[i] = 16'h0FFF;
    end
    base = done_cnt;
    start_run(1'b0);
    push_expected(6);
    fork
      drive_src(1'b0, 6, 0, 0);
      drive_src(1'b1, 6, 0, 0);
      sink(6, 0);
      begin
        repeat (3) @(negedge clk);
        ap_start = 1'b1;
        ap_sub = 1'b1;
        #1;
        check("pulse_in_run", dbg_state, ST_RUN);
        @(negedge clk);
        ap_start = 1'b0;
        ap_sub = 1'b0;
      end
    join
    wait_idle();
    check("pulse_count", beat_count, 32'd6);
    check("pulse_done", done_cnt - base, 1);
    check("pulse_keep_last", m_tkeep, 16'h0FFF);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
